// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: packet widths and field positions shared by the execute, memory,
// write-back and decode stages.
//   exe_rf   : {res_from_mem, rf_we, rf_waddr[4:0], alu_result[31:0]}
//   exe_load : {addr_lo[1:0], ld_hu, ld_bu, ld_h, ld_b, ld_w}
//   mem_rf   : {rf_we, rf_waddr[4:0], final_result[31:0]}
//   mem_fwd  : {valid & res_from_mem, valid & rf_we, rf_waddr[4:0], final_result[31:0]}
package mem_stage_pkg;

  localparam int unsigned ExeRfW   = 39;
  localparam int unsigned MemRfW   = 38;
  localparam int unsigned ExeLoadW = 7;
  localparam int unsigned MemFwdW  = 39;

  // exe_rf / mem_fwd field positions
  localparam int unsigned RfResFromMemBit = 38;
  localparam int unsigned RfWeBit         = 37;
  localparam int unsigned RfWaddrHi       = 36;
  localparam int unsigned RfWaddrLo       = 32;
  localparam int unsigned RfDataHi        = 31;

  // mem_rf field positions (no res_from_mem bit)
  localparam int unsigned MemRfWeBit = 37;

  // exe_load field positions
  localparam int unsigned LdAddrLoHi = 6;
  localparam int unsigned LdAddrLoLo = 5;
  localparam int unsigned LdFlagsHi  = 4;

  // Packed so that it overlays exe_load[4:0] directly.
  typedef struct packed {
    logic hu;
    logic bu;
    logic h;
    logic b;
    logic w;
  } ld_flags_t;

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: execute->memory handshake, SRAM read data and memory->write-back
// handshake bundled for the memory stage.
//   slave  : view used by mem_stage (drives MEM_* outputs)
//   master : view used by the surrounding pipeline (drives EXE_*, SRAM data, WB_allow_in)
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic                MEM_allow_in;
  logic                EXE_MEM_valid;
  logic [31:0]         EXE_pc;
  logic [ExeRfW-1:0]   EXE_rf;
  logic [ExeLoadW-1:0] EXE_load;
  logic [31:0]         data_sram_rdata;
  logic                WB_allow_in;
  logic                MEM_WB_valid;
  logic [31:0]         MEM_pc;
  logic [MemRfW-1:0]   MEM_rf;
  logic [MemFwdW-1:0]  MEM_fwd;

  modport slave (
    output MEM_allow_in, MEM_WB_valid, MEM_pc, MEM_rf, MEM_fwd,
    input  EXE_MEM_valid, EXE_pc, EXE_rf, EXE_load, data_sram_rdata, WB_allow_in
  );

  modport master (
    input  MEM_allow_in, MEM_WB_valid, MEM_pc, MEM_rf, MEM_fwd,
    output EXE_MEM_valid, EXE_pc, EXE_rf, EXE_load, data_sram_rdata, WB_allow_in
  );

endinterface

// File: rtl/mem_stage_load_align.sv
// mem_stage_load_align: combinational load extraction.
//   rdata     in  32  effective SRAM word
//   addr_lo   in  2   byte offset within the word
//   flags     in  5   {hu, bu, h, b, w}; at most one set, none means full word
//   load_data out 32  aligned, sign/zero-extended load result
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  ld_flags_t   flags,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    unique case (addr_lo)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    // Halfword offset uses addr_lo[1] only; alignment is guaranteed upstream.
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    load_data = rdata;
    case (flags)
      5'b00010: load_data = {{24{byte_sel[7]}}, byte_sel};
      5'b01000: load_data = {24'h0, byte_sel};
      5'b00100: load_data = {{16{half_sel[15]}}, half_sel};
      5'b10000: load_data = {16'h0, half_sel};
      default:  load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between execute and write-back.
//   clk  in   clock, posedge
//   rst  in   synchronous active-high reset
//   bus  slave modport of mem_stage_if:
//     EXE_* / EXE_MEM_valid in, MEM_allow_in out     execute handshake
//     data_sram_rdata in                             SRAM data, valid the cycle after request
//     MEM_WB_valid / MEM_pc / MEM_rf out, WB_allow_in in   write-back handshake
//     MEM_fwd out                                    bypass/hazard info for decode
// A one-entry buffer captures load data on the first stalled cycle so the result
// survives a write-back stall of any length.
module mem_stage
  import mem_stage_pkg::*;
(
  input logic       clk,
  input logic       rst,
  mem_stage_if.slave bus
);

  logic        mem_valid_q;
  logic [31:0] pc_q;
  logic        res_from_mem_q;
  logic        rf_we_q;
  logic [4:0]  rf_waddr_q;
  logic [31:0] alu_result_q;
  logic [1:0]  addr_lo_q;
  ld_flags_t   ld_flags_q;
  logic [31:0] rbuf_q;
  logic        rbuf_valid_q;

  logic        mem_ready_go;
  logic        allow_in;
  logic        accept;
  logic        rbuf_set;
  logic [31:0] rdata_eff;
  logic [31:0] load_data;
  logic [31:0] final_result;

  assign mem_ready_go = 1'b1;
  assign allow_in     = ~mem_valid_q | (mem_ready_go & bus.WB_allow_in);
  assign accept       = bus.EXE_MEM_valid & allow_in;
  // Only true while stalled, so it never coincides with a buffer clear.
  assign rbuf_set     = mem_valid_q & res_from_mem_q & ~rbuf_valid_q & ~bus.WB_allow_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid_q    <= 1'b0;
      pc_q           <= '0;
      res_from_mem_q <= 1'b0;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= '0;
      alu_result_q   <= '0;
      addr_lo_q      <= '0;
      ld_flags_q     <= '0;
      rbuf_q         <= '0;
      rbuf_valid_q   <= 1'b0;
    end else begin
      if (allow_in) begin
        mem_valid_q <= bus.EXE_MEM_valid;
      end
      if (accept) begin
        pc_q           <= bus.EXE_pc;
        res_from_mem_q <= bus.EXE_rf[RfResFromMemBit];
        rf_we_q        <= bus.EXE_rf[RfWeBit];
        rf_waddr_q     <= bus.EXE_rf[RfWaddrHi:RfWaddrLo];
        alu_result_q   <= bus.EXE_rf[RfDataHi:0];
        addr_lo_q      <= bus.EXE_load[LdAddrLoHi:LdAddrLoLo];
        ld_flags_q     <= bus.EXE_load[LdFlagsHi:0];
      end
      // Any advance of the stage (new packet or emptying) invalidates the buffer.
      if (allow_in) begin
        rbuf_valid_q <= 1'b0;
      end else if (rbuf_set) begin
        rbuf_valid_q <= 1'b1;
      end
      if (rbuf_set) begin
        rbuf_q <= bus.data_sram_rdata;
      end
    end
  end

  assign rdata_eff = rbuf_valid_q ? rbuf_q : bus.data_sram_rdata;

  mem_stage_load_align u_load_align (
    .rdata     (rdata_eff),
    .addr_lo   (addr_lo_q),
    .flags     (ld_flags_q),
    .load_data (load_data)
  );

  assign final_result = res_from_mem_q ? load_data : alu_result_q;

  assign bus.MEM_allow_in = allow_in;
  assign bus.MEM_WB_valid = mem_valid_q & mem_ready_go;
  assign bus.MEM_pc       = pc_q;
  assign bus.MEM_rf       = {mem_valid_q & rf_we_q, rf_waddr_q, final_result};
  assign bus.MEM_fwd      = {mem_valid_q & res_from_mem_q, mem_valid_q & rf_we_q,
                             rf_waddr_q, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against a packet-level
// reference model. The model tracks the packet held in the stage and the SRAM word
// that was present during its first cycle in the stage; that word is the load source
// for the whole residency regardless of how long write-back stalls.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_stage_if bif ();

  mem_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  int checks = 0;
  int errors = 0;

  // Reference model of the stage contents.
  bit          m_valid = 1'b0;
  bit          m_first = 1'b0;
  bit          m_res, m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_alu, m_pc, m_data;
  logic [1:0]  m_lo;
  logic [4:0]  m_flags;

  localparam logic [4:0] FHu = 5'b10000, FBu = 5'b01000, FH = 5'b00100, FB = 5'b00010,
                         FW  = 5'b00001;

  function automatic logic [31:0] load_ref(input logic [31:0] d, input logic [1:0] lo,
                                           input logic [4:0] f);
    logic [31:0] b, h;
    b = (d >> (32'(lo) * 8)) & 32'hFF;
    h = (d >> (32'(lo[1]) * 16)) & 32'hFFFF;
    if (f == FB)  return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
    if (f == FBu) return b;
    if (f == FH)  return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
    if (f == FHu) return h;
    return d;
  endfunction

  function automatic logic [38:0] rf_pkt(input bit res, input bit we, input logic [4:0] wa,
                                         input logic [31:0] alu);
    return {res, we, wa, alu};
  endfunction

  task automatic check(input string tag, input logic [38:0] obs, input logic [38:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs mid-cycle, advance the model.
  task automatic step(input bit v, input logic [31:0] pc, input logic [38:0] rf,
                      input logic [6:0] ld, input logic [31:0] rdata, input bit wb,
                      input bit use_lit, input logic [31:0] lit);
    logic [31:0] d, res;
    bit exp_allow;
    bif.EXE_MEM_valid   = v;
    bif.EXE_pc          = pc;
    bif.EXE_rf          = rf;
    bif.EXE_load        = ld;
    bif.data_sram_rdata = rdata;
    bif.WB_allow_in     = wb;
    exp_allow = !m_valid || wb;
    #4;
    if (!rst) begin
      check("allow_in", 39'(bif.MEM_allow_in), 39'(exp_allow));
      check("wb_valid", 39'(bif.MEM_WB_valid), 39'(m_valid));
      if (use_lit) check("result_const", 39'(bif.MEM_rf[31:0]), 39'(lit));
      if (m_valid) begin
        d   = m_first ? rdata : m_data;
        res = m_res ? load_ref(d, m_lo, m_flags) : m_alu;
        check("mem_pc", 39'(bif.MEM_pc), 39'(m_pc));
        check("mem_rf", 39'(bif.MEM_rf), 39'({m_we, m_waddr, res}));
        check("mem_fwd", bif.MEM_fwd, {m_res, m_we, m_waddr, res});
      end else begin
        check("idle_fwd_flags", 39'(bif.MEM_fwd[38:37]), 39'(0));
        check("idle_rf_we", 39'(bif.MEM_rf[MemRfWeBit]), 39'(0));
      end
    end
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0;
    end else if (exp_allow) begin
      m_valid = v;
      if (v) begin
        m_pc = pc; m_res = rf[38]; m_we = rf[37]; m_waddr = rf[36:32]; m_alu = rf[31:0];
        m_lo = ld[6:5]; m_flags = ld[4:0]; m_first = 1'b1;
      end
    end else begin
      if (m_first) m_data = rdata;
      m_first = 1'b0;
    end
    #1;
  endtask

  task automatic idle(input logic [31:0] rdata, input bit wb, input bit use_lit,
                      input logic [31:0] lit);
    step(1'b0, 32'h0, 39'h0, 7'h0, rdata, wb, use_lit, lit);
  endtask

  initial begin
    rst = 1'b1;
    idle(32'h0, 1'b1, 1'b0, 32'h0);
    idle(32'h0, 1'b1, 1'b0, 32'h0);
    rst = 1'b0;
    check("rst_wb_valid", 39'(bif.MEM_WB_valid), 39'(0));
    check("rst_allow_in", 39'(bif.MEM_allow_in), 39'(1));
    check("rst_fwd", bif.MEM_fwd, 39'(0));
    check("rst_pc", 39'(bif.MEM_pc), 39'(0));

    // Byte load, sign-extended from the top byte.
    step(1'b1, 32'h100, rf_pkt(1, 1, 5'd5, 32'hAAAA), {2'd3, FB}, 32'h0, 1'b1, 1'b0, 32'h0);
    idle(32'h80FF_1234, 1'b1, 1'b1, 32'hFFFF_FF80);

    // Halfword / word loads back to back.
    step(1'b1, 32'h104, rf_pkt(1, 1, 5'd6, 32'h0), {2'd2, FHu}, 32'h0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 32'h108, rf_pkt(1, 1, 5'd7, 32'h0), {2'd2, FH}, 32'h8001_7777, 1'b1,
         1'b1, 32'h0000_8001);
    step(1'b1, 32'h10C, rf_pkt(1, 1, 5'd8, 32'h0), {2'd0, FW}, 32'h8001_7777, 1'b1,
         1'b1, 32'hFFFF_8001);
    idle(32'h8001_7777, 1'b1, 1'b1, 32'h8001_7777);

    // Load stalled 4 cycles; SRAM data present only in the first.
    step(1'b1, 32'h200, rf_pkt(1, 1, 5'd9, 32'h0), {2'd0, FW}, 32'h0, 1'b1, 1'b0, 32'h0);
    idle(32'hDEAD_BEEF, 1'b0, 1'b1, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) idle(32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    idle(32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF);
    idle(32'h0, 1'b1, 1'b0, 32'h0);

    // Back-to-back ALU results, no bubbles.
    step(1'b1, 32'h300, rf_pkt(0, 1, 5'd1, 32'h10), 7'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 32'h304, rf_pkt(0, 1, 5'd2, 32'h20), 7'h0, 32'h0, 1'b1, 1'b1, 32'h10);
    step(1'b1, 32'h308, rf_pkt(0, 1, 5'd3, 32'h30), 7'h0, 32'h0, 1'b1, 1'b1, 32'h20);
    idle(32'h0, 1'b1, 1'b1, 32'h30);

    // Reset during a stalled load that already filled the buffer.
    step(1'b1, 32'h400, rf_pkt(1, 1, 5'd4, 32'h0), {2'd0, FW}, 32'h0, 1'b1, 1'b0, 32'h0);
    idle(32'h1111_2222, 1'b0, 1'b1, 32'h1111_2222);
    idle(32'h0, 1'b0, 1'b1, 32'h1111_2222);
    rst = 1'b1;
    idle(32'h0, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    check("rst_stall_valid", 39'(dut.mem_valid_q), 39'(0));
    check("rst_stall_rbuf_valid", 39'(dut.rbuf_valid_q), 39'(0));
    step(1'b1, 32'h500, rf_pkt(1, 1, 5'd10, 32'h0), {2'd0, FW}, 32'h0, 1'b0, 1'b0, 32'h0);
    idle(32'h3333_4444, 1'b0, 1'b1, 32'h3333_4444);
    idle(32'h0000_0055, 1'b0, 1'b1, 32'h3333_4444);
    idle(32'h0, 1'b1, 1'b1, 32'h3333_4444);

    // Randomized traffic with random stalls and per-cycle SRAM noise.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] fl;
      logic [1:0] lo;
      int k;
      k  = int'($urandom_range(0, 5));
      fl = (k == 5) ? 5'b0 : 5'(1 << k);
      lo = 2'($urandom_range(0, 3));
      if (fl == FH || fl == FHu) lo[0] = 1'b0;
      if (fl == FW) lo = 2'd0;
      step($urandom_range(0, 3) != 0, $urandom,
           {1'($urandom), 1'($urandom), 5'($urandom), 32'($urandom)}, {lo, fl},
           $urandom, $urandom_range(0, 3) != 0, 1'b0, 32'h0);
    end
    idle(32'h0, 1'b1, 1'b0, 32'h0);
    idle(32'h0, 1'b1, 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage that sits directly downstream of the execute stage and upstream of write-back. It accepts one instruction per cycle over the valid/allow-in handshake, and takes the synchronous data-SRAM read data that arrives the cycle after execute issued the request. It aligns and sign- or zero-extends load data and forwards the final register-file write packet to write-back. It also holds SRAM read data in a one-entry buffer, so a write-back stall never loses a load result.

## Interface
Parameters: none (widths fixed by the pipeline packet formats).
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- MEM_allow_in  out  1  stage can accept an instruction this cycle
- EXE_MEM_valid  in  1  execute-stage packet valid
- EXE_pc  in  32  pc of incoming instruction
- EXE_rf  in  39  {res_from_mem[38], rf_we[37], rf_waddr[36:32], alu_result[31:0]}
- EXE_load  in  7  {addr_lo[6:5], ld_hu[4], ld_bu[3], ld_h[2], ld_b[1], ld_w[0]}
- data_sram_rdata  in  32  SRAM read data, valid only in the cycle after the request
- WB_allow_in  in  1  write-back can accept
- MEM_WB_valid  out  1  packet to write-back valid
- MEM_pc  out  32  registered pc
- MEM_rf  out  38  {rf_we[37], rf_waddr[36:32], final_result[31:0]}
- MEM_fwd  out  39  {MEM_valid&res_from_mem[38], MEM_valid&rf_we[37], rf_waddr[36:32], final_result[31:0]}; bypass/hazard info for decode

## Operation
- Stage register: MEM_valid, pc, res_from_mem, rf_we, rf_waddr, alu_result, addr_lo, 5 load flags. All load when EXE_MEM_valid & MEM_allow_in.
- MEM_ready_go = 1 (no internal multi-cycle op).
- MEM_allow_in = ~MEM_valid | (MEM_ready_go & WB_allow_in).
- MEM_WB_valid = MEM_valid & MEM_ready_go.
- MEM_valid update: if MEM_allow_in, MEM_valid <= EXE_MEM_valid.
- Read-data buffer: rbuf[31:0], rbuf_valid.
  - Set rbuf <= data_sram_rdata and rbuf_valid <= 1 when MEM_valid & res_from_mem & ~rbuf_valid & ~WB_allow_in. This is the stalled first cycle.
  - Clear rbuf_valid whenever a new packet is accepted or MEM_valid drops.
  - rdata_eff = rbuf_valid ? rbuf : data_sram_rdata.
- Load extraction on rdata_eff:
  - ld_b / ld_bu: byte at addr_lo×8, sign- / zero-extended.
  - ld_h / ld_hu: halfword at addr_lo[1]×16, sign- / zero-extended.
  - ld_w, or no flag set: the full word.
- final_result = res_from_mem ? load_data : alu_result.
- MEM_rf rf_we is gated by MEM_valid.
- Misalignment is not checked here; execute guarantees alignment.

## Timing
- Reset values:
  - MEM_valid=0, rbuf_valid=0, MEM_pc=0, rbuf=0, stored fields=0.
  - Hence MEM_WB_valid=0, MEM_allow_in=1, MEM_fwd[38:37]=0.
- Latency: 1 cycle, from EXE acceptance to MEM_WB_valid.
- Throughput: 1 instruction/cycle when WB_allow_in=1.
- Request issued in cycle N, instruction captured at end of N. SRAM data is visible in N+1, the first MEM cycle.
- Stall (WB_allow_in=0): packet and outputs hold.
  - For loads, rdata is captured at the end of the first stalled cycle.
  - Later cycles use rbuf, so final_result is stable across any stall length.
- Simultaneous leave+enter: with WB_allow_in=1, the old packet leaves and the new one is captured in the same edge. rbuf_valid is cleared that edge.
- EXE_MEM_valid=0 with allow_in=1: the stage empties and data fields are don't-care.
- rst mid-stall: the packet is dropped and rbuf_valid cleared on the same edge.

## Structure
- Shared package/header: packet width constants (39/38/7/39) and field bit positions for EXE_rf, EXE_load, MEM_rf, MEM_fwd. These are shared with the execute, write-back and decode stages.
- One natural sub-module, load_align: combinational rdata_eff + addr_lo + flags → load_data. It is reused by any future unaligned/cache path.
- Everything else (handshake, stage register, rbuf) stays in mem_stage.

## Test plan
- Reset: hold rst 2 cycles → MEM_WB_valid=0, MEM_allow_in=1, MEM_fwd[38:37]=0.
- ld_b, addr_lo=3, rdata=0x80FF_1234, WB_allow_in=1 → next cycle final_result=0xFFFF_FF80, rf_we=1.
- ld_hu, addr_lo=2, rdata=0x8001_7777 → 0x0000_8001. ld_h same → 0xFFFF_8001. ld_w → 0x8001_7777.
- Load with WB_allow_in=0 for 4 cycles, rdata 0xDEAD_BEEF only in first cycle then 0x0 → final_result stays 0xDEAD_BEEF all 4 cycles, MEM_allow_in=0; release → one MEM_WB_valid pulse.
- Back-to-back non-loads, alu_result 0x10,0x20,0x30, WB_allow_in=1 → MEM_rf results 0x10,0x20,0x30 on consecutive cycles, no bubbles.
- rst asserted during a stalled load → next cycle MEM_valid=0, rbuf_valid=0; the following load uses fresh SRAM data, not the stale buffer.
